// File: rtl/fifo_rd_stream_adapter.sv
// Purpose : adapts an async-FIFO read port (empty / rd_en / 1-cycle read data) to a valid/ready stream.
// Latency : rd_en in the cycle the FIFO shows non-empty; the word lands in the buffer one edge after the read edge.
// Backpr. : holds at most 2 words (held + in flight); rd_en drops at occ=2 and resumes in the cycle of a pop.
//
// Ports
//   i_clk, i_rst_n  FIFO read clock; asynchronous active-low reset, released on the clock edge
//   i_flush         synchronous flush of held and in-flight words
//   i_fifo_empty    FIFO empty flag
//   o_fifo_rd_en    FIFO read strobe (combinational)
//   i_fifo_data     FIFO read data, valid one cycle after o_fifo_rd_en
//   o_valid/i_ready/o_data  output stream; o_data is the registered head entry
//   o_xfer_cnt      accepted-word counter, wraps modulo 2^CNT_W
//                   (present only when FIFO_RD_XFER_CNT_EN is defined)
//
// Build option: define FIFO_RD_XFER_CNT_EN to add o_xfer_cnt and its counter.

module fifo_rd_stream_adapter #(
  parameter int SIZE_DATA = 8
`ifdef FIFO_RD_XFER_CNT_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_rd_en,
  input  logic [SIZE_DATA-1:0] i_fifo_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data
`ifdef FIFO_RD_XFER_CNT_EN
  ,
  output logic [CNT_W-1:0]     o_xfer_cnt
`endif
);

  // Two-entry output buffer: head feeds o_data directly, tail is the overflow slot.
  logic                 head_vld;
  logic                 tail_vld;
  logic [SIZE_DATA-1:0] head_dat;
  logic [SIZE_DATA-1:0] tail_dat;

  logic                 head_vld_nxt;
  logic                 tail_vld_nxt;
  logic [SIZE_DATA-1:0] head_dat_nxt;
  logic [SIZE_DATA-1:0] tail_dat_nxt;

  // A read was issued on the previous edge; its data is on i_fifo_data now.
  logic                 inflight;

  logic [1:0]           occ;
  logic                 pop;
  logic                 rd_en;

  assign pop = head_vld & i_ready;

  // Held entries plus the outstanding read; the read strobe keeps this at or below 2.
  assign occ = {1'b0, head_vld} + {1'b0, tail_vld} + {1'b0, inflight};

  // A pop this cycle frees a slot that the new read will fill two edges later,
  // so reading at occ=2 is safe when the head is leaving. Gated by reset so the
  // FIFO is never strobed while this block is held in reset.
  assign rd_en = i_rst_n & ~i_fifo_empty & ~i_flush & ((occ < 2'd2) | pop);

  assign o_fifo_rd_en = rd_en;
  assign o_valid      = head_vld;
  assign o_data       = head_dat;

  // Buffer update. Order is preserved by always refilling the head from the
  // tail before placing a newly arrived word behind it.
  always_comb begin
    head_vld_nxt = head_vld;
    tail_vld_nxt = tail_vld;
    head_dat_nxt = head_dat;
    tail_dat_nxt = tail_dat;

    if (i_flush) begin
      // The word arriving this cycle (read issued last cycle) is dropped too.
      head_vld_nxt = 1'b0;
      tail_vld_nxt = 1'b0;
    end else begin
      case ({pop, inflight})
        2'b10: begin
          // Pop only: tail (if any) moves up.
          head_vld_nxt = tail_vld;
          tail_vld_nxt = 1'b0;
          if (tail_vld) begin
            head_dat_nxt = tail_dat;
          end
        end
        2'b01: begin
          // Capture only: land in the first free slot.
          if (head_vld) begin
            tail_vld_nxt = 1'b1;
            tail_dat_nxt = i_fifo_data;
          end else begin
            head_vld_nxt = 1'b1;
            head_dat_nxt = i_fifo_data;
          end
        end
        2'b11: begin
          // Pop and capture together: occupancy unchanged.
          if (tail_vld) begin
            head_dat_nxt = tail_dat;
            tail_dat_nxt = i_fifo_data;
          end else begin
            head_dat_nxt = i_fifo_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
      head_dat <= '0;
      tail_dat <= '0;
      inflight <= 1'b0;
    end else begin
      head_vld <= head_vld_nxt;
      tail_vld <= tail_vld_nxt;
      head_dat <= head_dat_nxt;
      tail_dat <= tail_dat_nxt;
      // rd_en is already low during flush, so this also clears the in-flight flag.
      inflight <= rd_en;
    end
  end

`ifdef FIFO_RD_XFER_CNT_EN
  // Counts every accepted word, including one popped on a flush edge.
  // Only reset clears it; flush leaves it alone.
  logic [CNT_W-1:0] xfer_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      xfer_cnt <= '0;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  assign o_xfer_cnt = xfer_cnt;
`endif

endmodule
